// File: rtl/led_fader_pkg.sv
// Shared types for the LED fader: FSM state enum and phase encodings.
package led_fader_pkg;

  typedef enum logic [1:0] {
    RAMP_UP   = 2'd0,
    HOLD_HI   = 2'd1,
    RAMP_DOWN = 2'd2,
    HOLD_LO   = 2'd3
  } fade_state_t;

  localparam logic [1:0] PHASE_RAMP_UP   = 2'd0;
  localparam logic [1:0] PHASE_HOLD_HI   = 2'd1;
  localparam logic [1:0] PHASE_RAMP_DOWN = 2'd2;
  localparam logic [1:0] PHASE_HOLD_LO   = 2'd3;

endpackage

// File: rtl/pwm_gen.sv
// PWM generator: free-running counter, period-boundary duty latch, registered LED drive.
module pwm_gen #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic [PWM_BITS-1:0] duty,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_led;

  // Duty only updates at the end of a period so a level change never splits one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_led  <= 1'b0;
    end else begin
      r_led <= en & (r_cnt < r_duty);
      if (en) begin
        r_cnt <= r_cnt + PWM_BITS'(1);
        if (r_cnt == MAX) begin
          r_duty <= duty;
        end
      end
    end
  end

  assign led = r_led;

endmodule

// File: rtl/led_fader.sv
// LED fader: tick-paced ramp/hold FSM driving a PWM generator.
// Optional LED_FADER_GAMMA_EN squares the level into the PWM duty.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned STEP       = 1,
  parameter int unsigned HOLD_TICKS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                tick,
  output logic                led,
  output logic [PWM_BITS-1:0] level,
  output logic [1:0]          phase
);

  localparam int unsigned LW = PWM_BITS + 1;
  localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam logic [LW-1:0]       MAX_W     = {1'b0, MAX};
  localparam logic [LW-1:0]       STEP_W    = LW'(STEP);
  localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_TICKS - 1);

  fade_state_t         r_state;
  logic [PWM_BITS-1:0] r_level;
  logic [HW-1:0]       r_hold_cnt;

  logic [LW-1:0]       w_up;
  logic [LW-1:0]       w_down;
  logic                w_floor;
  logic [PWM_BITS-1:0] w_duty;

  // One extra bit makes overflow and borrow visible for exact saturation.
  assign w_up    = {1'b0, r_level} + STEP_W;
  assign w_down  = {1'b0, r_level} - STEP_W;
  assign w_floor = w_down[PWM_BITS] || (w_down == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RAMP_UP;
      r_level    <= '0;
      r_hold_cnt <= '0;
    end else if (en && tick) begin
      case (r_state)
        RAMP_UP: begin
          if (w_up >= MAX_W) begin
            r_level <= MAX;
            r_state <= HOLD_HI;
          end else begin
            r_level <= w_up[PWM_BITS-1:0];
          end
        end
        HOLD_HI: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_hold_cnt <= '0;
            r_state    <= RAMP_DOWN;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        RAMP_DOWN: begin
          if (w_floor) begin
            r_level <= '0;
            r_state <= HOLD_LO;
          end else begin
            r_level <= w_down[PWM_BITS-1:0];
          end
        end
        HOLD_LO: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_hold_cnt <= '0;
            r_state    <= RAMP_UP;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        default: r_state <= RAMP_UP;
      endcase
    end
  end

`ifdef LED_FADER_GAMMA_EN
  localparam int unsigned GW = 2 * PWM_BITS;
  assign w_duty = PWM_BITS'((GW'(r_level) * GW'(r_level)) >> PWM_BITS);
`else
  assign w_duty = r_level;
`endif

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .duty    (w_duty),
    .led     (led)
  );

  assign level = r_level;
  assign phase = r_state;

endmodule

// File: tb/tb_led_fader.sv
// Scoreboard bench for led_fader (PWM_BITS=4, STEP=4, HOLD_TICKS=2).
module tb_led_fader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       tick;
  logic       led;
  logic [3:0] level;
  logic [1:0] phase;

  typedef struct {
    logic [3:0] lvl;
    logic [1:0] ph;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  logic fire;

  led_fader #(
    .PWM_BITS   (4),
    .STEP       (4),
    .HOLD_TICKS (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .tick    (tick),
    .led     (led),
    .level   (level),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  function automatic int exp_high(input int lv);
`ifdef LED_FADER_GAMMA_EN
    return (lv * lv) >> 4;
`else
    return lv;
`endif
  endfunction

  // Monitor: an accepted tick produces a new level/phase after its edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) fire <= 1'b0;
    else          fire <= tick & en;
  end

  always @(negedge clk) begin
    exp_t e;
    if (fire) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("tick_level", int'(level), int'(e.lvl));
        check("tick_phase", int'(phase), int'(e.ph));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick(input logic [3:0] lv, input logic [1:0] ph);
    exp_t e;
    @(negedge clk);
    e.lvl = lv;
    e.ph  = ph;
    sb_q.push_back(e);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic measure(input string name, input int lv);
    int hi;
    hi = 0;
    idle(32);
    repeat (16) begin
      @(negedge clk);
      if (led) hi++;
    end
    check(name, hi, exp_high(lv));
  endtask

  initial begin
    int lv_tab[10];
    int ph_tab[10];
    lv_tab = '{15, 15, 11, 7, 3, 0, 0, 0, 4, 8};
    ph_tab = '{1, 2, 2, 2, 2, 3, 3, 0, 0, 0};

    reset_n = 1'b0;
    en      = 1'b0;
    tick    = 1'b0;
    idle(3);
    check("reset_level", int'(level), 0);
    check("reset_phase", int'(phase), 0);
    check("reset_led", int'(led), 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    en = 1'b1;

    // Ramp up with duty measurements at each level
    measure("duty_l0", 0);
    do_tick(4'd4, 2'd0);
    measure("duty_l4", 4);
    do_tick(4'd8, 2'd0);
    measure("duty_l8", 8);
    do_tick(4'd12, 2'd0);
    measure("duty_l12", 12);
    do_tick(4'd15, 2'd1);
    measure("duty_l15", 15);

    // Hold high, ramp down, hold low, back to ramp up
    for (int i = 0; i < 10; i++) begin
      idle(19);
      do_tick(4'(lv_tab[i]), 2'(ph_tab[i]));
    end

    // Enable drop with a coincident tick: frozen, led forced low
    idle(19);
    @(negedge clk);
    en   = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("gate_led", int'(led), 0);
    check("gate_level", int'(level), 8);
    check("gate_phase", int'(phase), 0);
    idle(5);
    check("gate_led_hold", int'(led), 0);
    check("gate_level_hold", int'(level), 8);
    @(negedge clk);
    en = 1'b1;
    do_tick(4'd12, 2'd0);

    // Asynchronous reset between edges at level 12
    idle(20);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_level", int'(level), 0);
    check("async_phase", int'(phase), 0);
    check("async_led", int'(led), 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    do_tick(4'd4, 2'd0);

    idle(5);
    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8, as the width of the duty level and PWM counter.
REQ-002 SHALL have parameter STEP, default 1, as the level increment or decrement per tick.
REQ-003 SHALL have parameter HOLD_TICKS, default 16, as the number of ticks to dwell at each extreme (range 1 or more).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all flops are on posedge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1 bit: run enable.
REQ-007 SHALL have port tick, input, 1 bit: one-cycle strobe from the upstream clock divider that paces level changes.
REQ-008 SHALL have port led, output, 1 bit: PWM-modulated LED drive.
REQ-009 SHALL have port level, output, PWM_BITS bits: current brightness level.
REQ-010 SHALL have port phase, output, 2 bits: current FSM state encoding.

Function
REQ-011 SHALL implement FSM states RAMP_UP=0, HOLD_HI=1, RAMP_DOWN=2, HOLD_LO=3, with phase equal to the state.
REQ-012 SHALL act on state, level and hold counter only in cycles where tick=1 and en=1.
REQ-013 RAMP_UP: level SHALL become level+STEP; if level+STEP >= MAX (2^PWM_BITS-1), level SHALL become MAX and the state SHALL become HOLD_HI in the same cycle (no wrap).
REQ-014 RAMP_DOWN: level SHALL become level-STEP; if level <= STEP, level SHALL become 0 and the state SHALL become HOLD_LO (no underflow).
REQ-015 HOLD_HI and HOLD_LO: hold_cnt SHALL increment per tick; on the tick where hold_cnt==HOLD_TICKS-1, hold_cnt SHALL clear and the state SHALL advance to RAMP_DOWN or RAMP_UP respectively.
REQ-016 SHALL compute intermediate arithmetic at PWM_BITS+1 bits so that saturation detection is exact.
REQ-017 SHALL implement a PWM counter pwm_cnt of PWM_BITS bits that increments every cycle while en=1 and wraps from MAX to 0.
REQ-018 SHALL latch duty from the level path only in the cycle where pwm_cnt==MAX, so duty changes only at period boundaries.
REQ-019 SHALL register led as led <= en & (pwm_cnt < duty), giving one cycle of latency from counter to pin.
REQ-020 Boundary: duty=0 SHALL keep led low for the whole period; duty=MAX SHALL keep led high for MAX of 2^PWM_BITS cycles.
REQ-021 en=0 SHALL freeze state, level, hold_cnt, pwm_cnt and duty, and SHALL force led=0 on the next edge.
REQ-022 When en rises again, operation SHALL resume from the frozen values.
REQ-023 A tick arriving in the same cycle as en=0 SHALL be ignored.

Reset
REQ-024 reset_n=0 SHALL asynchronously force state=RAMP_UP, level=0, hold_cnt=0, pwm_cnt=0, duty=0 and led=0.
REQ-025 Release of reset_n SHALL take effect on the next posedge; reset asserted mid-ramp SHALL abandon the ramp with no residual state.

Configuration
REQ-026 With LED_FADER_GAMMA_EN defined, duty SHALL latch (level*level)>>PWM_BITS, computed at 2*PWM_BITS bits, for perceptual linearity.
REQ-027 Without LED_FADER_GAMMA_EN, duty SHALL latch level directly; the level output SHALL be ungammaed in both builds.

Structure
REQ-028 Package led_fader_pkg SHALL hold the fade_state_t enum and the phase encodings.
REQ-029 The PWM counter, duty latch and led register SHALL live in sub-module pwm_gen (parameter PWM_BITS; ports clk, reset_n, en, duty, led).
REQ-030 The FSM, level and hold_cnt logic SHALL remain in led_fader.

Verification (PWM_BITS=4, STEP=4, HOLD_TICKS=2, gamma off unless stated)
REQ-031 Ramp up: reset, then en=1 with ticks every 20 cycles -> level 0,4,8,12,15; phase goes 0 to 1 on the tick that reaches 15.
REQ-032 Hold and ramp down: continue ticking -> two ticks in HOLD_HI, then level 11,7,3,0, HOLD_LO for two ticks, then RAMP_UP.
REQ-033 PWM duty: hold level=8 -> led high for exactly 8 of every 16 cycles; level=0 -> led never high; level=15 -> led high for 15 of 16.
REQ-034 Enable gating: drop en mid-ramp with tick pulsed at the same cycle -> led=0 next edge and level unchanged; re-raise en -> resumes from the same level and phase.
REQ-035 Async reset: assert reset_n low between clock edges at level=12 -> outputs are zero immediately, with no clock edge required.
REQ-036 Gamma: build with LED_FADER_GAMMA_EN and level=12 -> 9 of 16 cycles high; level=4 -> 1 of 16.
